fpga_io_conditioner: RTL and testbench
======================================

Name: fpga_io_conditioner

Overview:
- Parametrised pad-side input conditioning stage for the FPGA top-level wrapper.
- Sits between the pad ring (after IBUF/IBUFG) and the core_v_mcu `io` bus.
- Per channel: synchroniser, programmable glitch filter and edge-event generator.
- Clock-capable pins (sysclk, JTAG TCK) are bypassed via mask and pass through untouched.

Parameters:
- N_IO, 48, number of pad channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth; legal range 2..4.
- FILT_W, 8, width of filter-length config and per-channel counter.
- BYPASS_MASK, 48'h140 (bits 6 and 8), channels passed combinationally with no sync, filter or events.
- RESET_VAL, {N_IO{1'b0}}, per-channel reset value of synchroniser, filter state and io_o.

Ports:
- clk_i  input  1  conditioning clock.
- rst_i  input  1  asynchronous, active-high reset.
- pad_i  input  N_IO  raw pad inputs, asynchronous to clk_i.
- filt_en_i  input  N_IO  per-channel filter enable.
- filt_len_i  input  FILT_W  stable cycles required beyond the first before output accepts a change (shared).
- io_o  output  N_IO  conditioned level to core.
- rise_o  output  N_IO  one-cycle pulse on io_o 0->1 (non-bypass channels).
- fall_o  output  N_IO  one-cycle pulse on io_o 1->0 (non-bypass channels).

Behaviour:
- Reset state:
  - sync chain and filtered level = RESET_VAL; counters = 0; rise_o/fall_o = 0.
  - io_o = RESET_VAL on non-bypass bits; bypass bits = pad_i.
- Bypass channel (BYPASS_MASK[i]=1): io_o[i]=pad_i[i] combinationally; rise_o[i]=fall_o[i]=0 always; no flops instantiated.
- Synchroniser: s[i] = pad_i[i] after SYNC_STAGES clk_i edges.
- Filter, per non-bypass channel, one counter cnt[FILT_W-1:0]:
  - s==filt: cnt<=0.
  - s!=filt and (filt_en_i==0 or cnt>=filt_len_i): filt<=s, cnt<=0.
  - otherwise: cnt<=cnt+1, saturating at all-ones; no wrap.
- Latency pad->io_o:
  - Filter enabled: SYNC_STAGES + filt_len_i + 1 cycles.
  - Filter disabled or filt_len_i=0: SYNC_STAGES + 1 cycles.
- Glitch rejection: pulse (either polarity) shorter than filt_len_i+1 synchronised cycles never reaches io_o; counter restarts on every bounce.
- Config changes mid-count: the `>=` compare applies the new value on the next cycle.
  - Lowering filt_len_i below the current cnt commits on the next edge.
  - Raising it extends the wait.
  - filt_en_i falling while a count is pending commits on the next edge.
- io_o[i] = filt[i] (registered).
- Edges: rise_o[i]/fall_o[i] asserted for exactly the one cycle in which io_o[i] first shows the new value. Never both asserted on one channel. Consecutive edges on a channel are at least 1 cycle apart.
- Reset mid-operation: asynchronous clear to reset state; no edge pulse is generated on reset assertion or deassertion.

Optional Feature:
- Macro: FPGA_IO_COND_STICKY_EN.
- When defined:
  - Adds inputs sticky_clr_i[N_IO] and output sticky_o[N_IO].
  - sticky_o[i] set by rise_o[i]|fall_o[i], held until sticky_clr_i[i].
  - Simultaneous set and clear: set wins.
  - Reset value 0; bypass bits tied 0.
- When undefined: ports and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package fpga_io_pkg:
  - N_IO_DEFAULT.
  - FILT_W_DEFAULT.
  - typedef filt_len_t (logic [FILT_W_DEFAULT-1:0]).
  - BYPASS_MASK_DEFAULT with named pin constants SYSCLK_PIN=6, JTAG_TCK_PIN=8.
- Sub-module fpga_io_cond_chan: one non-bypass channel (sync, filter, counter, edge, optional sticky).
- Top level: generate loop selecting chan instance vs wire by BYPASS_MASK.

Test Plan:
- Reset: rst_i=1 with pad_i toggling -> io_o=RESET_VAL on non-bypass bits, rise_o=fall_o=0. Deassert rst_i -> no edge pulse.
- Latency: SYNC_STAGES=2, filt_len_i=3, filt_en_i=1, pad_i[0] 0->1 held -> io_o[0] rises exactly 6 cycles later, with rise_o[0] high for that single cycle.
- Glitch reject: filt_len_i=3, 3-cycle high pulse on pad_i[1] -> io_o[1] stays 0, no rise_o. 4-cycle pulse -> io_o[1] high for 4 cycles, one rise_o and one fall_o.
- Filter off / bypass: filt_en_i[2]=0, pad_i[2] toggles -> io_o follows after 3 cycles. pad_i[6] and pad_i[8] -> io_o same cycle, rise_o/fall_o bits 6 and 8 always 0.
- Config change mid-count: filt_len_i=200, pad_i[3] high for 10 cycles, then filt_len_i=5 -> io_o[3] rises on the next edge. Separately, filt_len_i=255 held with pad_i stable and differing -> counter saturates and commits exactly once.
- Sticky (macro on): edge on pad_i[4] -> sticky_o[4]=1 until sticky_clr_i[4]. Clear coincident with a new fall_o[4] -> sticky_o[4] remains 1.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// Shared constants and types for the pad-side input conditioner.
// Pin constants name the clock-capable pads that must bypass conditioning.
package fpga_io_pkg;

    localparam int N_IO_DEFAULT   = 48;
    localparam int FILT_W_DEFAULT = 8;

    localparam int SYSCLK_PIN   = 6;
    localparam int JTAG_TCK_PIN = 8;

    localparam logic [N_IO_DEFAULT-1:0] BYPASS_MASK_DEFAULT =
        (N_IO_DEFAULT'(1) << SYSCLK_PIN) | (N_IO_DEFAULT'(1) << JTAG_TCK_PIN);

    typedef logic [FILT_W_DEFAULT-1:0] filt_len_t;

endpackage

// File: rtl/fpga_io_cond_chan.sv
// One conditioned pad channel: synchroniser, glitch filter, edge pulses (sticky flag with FPGA_IO_COND_STICKY_EN).
// Latency SYNC_STAGES + filt_len_i + 1 cycles (filter on), SYNC_STAGES + 1 (filter off); no backpressure.
module fpga_io_cond_chan
    import fpga_io_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = FILT_W_DEFAULT,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pad_i,
    input  logic              filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
`ifdef FPGA_IO_COND_STICKY_EN
    input  logic              sticky_clr_i,
    output logic              sticky_o,
`endif
    output logic              io_o,
    output logic              rise_o,
    output logic              fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   filt_q;
    logic [FILT_W-1:0]      cnt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   differs;
    logic                   commit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign differs = (sync_s != filt_q);
    // Config inputs are compared live, so a lowered length or a dropped enable commits on the next edge.
    assign commit  = differs && (!filt_en_i || (cnt_q >= filt_len_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= RESET_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= commit && sync_s;
            fall_q <= commit && !sync_s;
            if (!differs || commit) begin
                cnt_q <= '0;
            end else if (cnt_q != {FILT_W{1'b1}}) begin
                cnt_q <= cnt_q + FILT_W'(1);
            end
            if (commit) begin
                filt_q <= sync_s;
            end
        end
    end

    assign io_o   = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef FPGA_IO_COND_STICKY_EN
    logic sticky_q;

    // Set beats clear so an edge landing in the clear cycle is not lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (rise_q || fall_q) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_o = sticky_q;
`endif

endmodule

// File: rtl/fpga_io_conditioner.sv
// Pad-ring input conditioner: per-channel sync/filter/edge detect, clock pins bypassed (sticky flags with FPGA_IO_COND_STICKY_EN).
// Latency SYNC_STAGES + filt_len_i + 1 (bypass channels combinational); no backpressure.
module fpga_io_conditioner
    import fpga_io_pkg::*;
#(
    parameter int              N_IO        = N_IO_DEFAULT,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_W      = FILT_W_DEFAULT,
    parameter logic [N_IO-1:0] BYPASS_MASK = N_IO'(BYPASS_MASK_DEFAULT),
    parameter logic [N_IO-1:0] RESET_VAL   = {N_IO{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_IO-1:0]   pad_i,
    input  logic [N_IO-1:0]   filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
`ifdef FPGA_IO_COND_STICKY_EN
    input  logic [N_IO-1:0]   sticky_clr_i,
    output logic [N_IO-1:0]   sticky_o,
`endif
    output logic [N_IO-1:0]   io_o,
    output logic [N_IO-1:0]   rise_o,
    output logic [N_IO-1:0]   fall_o
);

    for (genvar i = 0; i < N_IO; i++) begin : g_chan
        if (BYPASS_MASK[i]) begin : g_bypass
            // Clock-capable pads must not see any flop delay or filtering.
            assign io_o[i]   = pad_i[i];
            assign rise_o[i] = 1'b0;
            assign fall_o[i] = 1'b0;
`ifdef FPGA_IO_COND_STICKY_EN
            assign sticky_o[i] = 1'b0;
            logic unused_cfg;
            assign unused_cfg = filt_en_i[i] ^ sticky_clr_i[i];
`else
            logic unused_cfg;
            assign unused_cfg = filt_en_i[i];
`endif
        end else begin : g_cond
            fpga_io_cond_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_W      (FILT_W),
                .RESET_VAL   (RESET_VAL[i])
            ) u_chan (
                .clk_i        (clk_i),
                .rst_i        (rst_i),
                .pad_i        (pad_i[i]),
                .filt_en_i    (filt_en_i[i]),
                .filt_len_i   (filt_len_i),
`ifdef FPGA_IO_COND_STICKY_EN
                .sticky_clr_i (sticky_clr_i[i]),
                .sticky_o     (sticky_o[i]),
`endif
                .io_o         (io_o[i]),
                .rise_o       (rise_o[i]),
                .fall_o       (fall_o[i])
            );
        end
    end

endmodule

// File: tb/tb_fpga_io_conditioner.sv
// Scoreboard bench for fpga_io_conditioner: expected edge events are queued with their cycle,
// a negedge monitor pops and compares every rise/fall pulse; level checks are made inline.
module tb_fpga_io_conditioner;

    localparam int N = 48;
    localparam logic [N-1:0] BYP = (N'(1) << 6) | (N'(1) << 8);

    logic         clk_i;
    logic         rst_i;
    logic [N-1:0] pad_i;
    logic [N-1:0] filt_en_i;
    logic [7:0]   filt_len_i;
    logic [N-1:0] io_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
`ifdef FPGA_IO_COND_STICKY_EN
    logic [N-1:0] sticky_clr_i;
    logic [N-1:0] sticky_o;
`endif

    fpga_io_conditioner dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pad_i        (pad_i),
        .filt_en_i    (filt_en_i),
        .filt_len_i   (filt_len_i),
`ifdef FPGA_IO_COND_STICKY_EN
        .sticky_clr_i (sticky_clr_i),
        .sticky_o     (sticky_o),
`endif
        .io_o         (io_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o)
    );

    typedef struct {
        int ch;
        bit rise;
        int cyc;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  cyc;
    int  n_cmp;
    int  n_err;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every pulse on any channel must match the head of the expected-event queue.
    always @(negedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (rise_o[i] || fall_o[i]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got ch=%0d rise=%0b fall=%0b cyc=%0d, required no pulse",
                             i, rise_o[i], fall_o[i], cyc);
                end else begin
                    e = q.pop_front();
                    if (e.ch != i || e.rise != rise_o[i] || rise_o[i] == fall_o[i] || e.cyc != cyc) begin
                        n_err++;
                        $display("FAIL edge_event: got ch=%0d rise=%0b fall=%0b cyc=%0d, required ch=%0d rise=%0b fall=%0b cyc=%0d",
                                 i, rise_o[i], fall_o[i], cyc, e.ch, e.rise, !e.rise, e.cyc);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input int ch, input bit rise, input int at);
        ev_t x;
        x.ch = ch;
        x.rise = rise;
        x.cyc = at;
        q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    int t0;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_i = 1'b1;
        pad_i = '0;
        filt_en_i = ~N'(1 << 2);
        filt_len_i = 8'd3;
`ifdef FPGA_IO_COND_STICKY_EN
        sticky_clr_i = '0;
`endif
        // Reset held while pads toggle
        for (int k = 0; k < 5; k++) begin
            pad_i = {$urandom, $urandom};
            step(1);
            chk("reset_io", io_o & ~BYP, '0);
            chk("reset_bypass", io_o & BYP, pad_i & BYP);
            chk("reset_edges", rise_o | fall_o, '0);
        end
        pad_i = '0;
        step(1);
        rst_i = 1'b0;
        step(6);
        chk("post_reset_io", io_o, '0);

        // Latency with filter, len 3: rise 6 cycles after the change
        t0 = cyc; pad_i[0] = 1'b1; expect_ev(0, 1, t0 + 6);
        step(5);
        chk("lat_before", N'(io_o[0]), N'(0));
        step(1);
        chk("lat_at", N'(io_o[0]), N'(1));
        t0 = cyc; pad_i[0] = 1'b0; expect_ev(0, 0, t0 + 6);
        step(8);

        // 3-cycle glitch rejected
        pad_i[1] = 1'b1;
        step(3);
        pad_i[1] = 1'b0;
        step(10);
        chk("glitch3_io", N'(io_o[1]), N'(0));
        // 4-cycle pulse passes, high for 4 cycles
        t0 = cyc; pad_i[1] = 1'b1; expect_ev(1, 1, t0 + 6); expect_ev(1, 0, t0 + 10);
        step(4);
        pad_i[1] = 1'b0;
        step(4);
        chk("pulse4_high", N'(io_o[1]), N'(1));
        step(4);
        chk("pulse4_low", N'(io_o[1]), N'(0));

        // Filter disabled on channel 2: 3-cycle latency, single-cycle pulses pass
        t0 = cyc; pad_i[2] = 1'b1; expect_ev(2, 1, t0 + 3);
        step(2);
        chk("nofilt_before", N'(io_o[2]), N'(0));
        step(1);
        chk("nofilt_at", N'(io_o[2]), N'(1));
        t0 = cyc; pad_i[2] = 1'b0; expect_ev(2, 0, t0 + 3);
        step(4);
        t0 = cyc; pad_i[2] = 1'b1; expect_ev(2, 1, t0 + 3);
        step(1);
        pad_i[2] = 1'b0; expect_ev(2, 0, t0 + 4);
        step(5);

        // Bypass pins follow combinationally
        pad_i[6] = 1'b1; #1;
        chk("bypass6_hi", N'(io_o[6]), N'(1));
        pad_i[8] = 1'b1; #1;
        chk("bypass8_hi", N'(io_o[8]), N'(1));
        pad_i[6] = 1'b0; #1;
        chk("bypass6_lo", N'(io_o[6]), N'(0));
        pad_i[8] = 1'b0;
        step(2);
        chk("bypass8_lo", N'(io_o[8]), N'(0));

        // Lowering the length mid-count commits on the next edge
        filt_len_i = 8'd200;
        t0 = cyc; pad_i[3] = 1'b1; expect_ev(3, 1, t0 + 13);
        step(12);
        filt_len_i = 8'd5;
        step(1);
        chk("lower_len_io", N'(io_o[3]), N'(1));
        filt_len_i = 8'd3;
        step(2);
        // Dropping the enable mid-count commits on the next edge
        filt_len_i = 8'd200;
        t0 = cyc; pad_i[3] = 1'b0; expect_ev(3, 0, t0 + 9);
        step(8);
        filt_en_i[3] = 1'b0;
        step(1);
        chk("en_drop_io", N'(io_o[3]), N'(0));
        filt_en_i[3] = 1'b1;
        filt_len_i = 8'd3;
        step(2);

        // Raising the length extends the wait
        t0 = cyc; pad_i[5] = 1'b1; expect_ev(5, 1, t0 + 13);
        step(4);
        filt_len_i = 8'd10;
        step(8);
        chk("raise_len_before", N'(io_o[5]), N'(0));
        step(1);
        chk("raise_len_at", N'(io_o[5]), N'(1));
        filt_len_i = 8'd3;
        step(2);

        // Saturating counter at len 255 commits exactly once
        filt_len_i = 8'd255;
        t0 = cyc; pad_i[7] = 1'b1; expect_ev(7, 1, t0 + 258);
        step(257);
        chk("sat_before", N'(io_o[7]), N'(0));
        step(1);
        chk("sat_at", N'(io_o[7]), N'(1));
        step(20);
        filt_len_i = 8'd3;

`ifdef FPGA_IO_COND_STICKY_EN
        t0 = cyc; pad_i[4] = 1'b1; expect_ev(4, 1, t0 + 6);
        step(7);
        chk("sticky_set", N'(sticky_o[4]), N'(1));
        step(3);
        chk("sticky_hold", N'(sticky_o[4]), N'(1));
        sticky_clr_i[4] = 1'b1;
        step(1);
        sticky_clr_i[4] = 1'b0;
        chk("sticky_clr", N'(sticky_o[4]), N'(0));
        t0 = cyc; pad_i[4] = 1'b0; expect_ev(4, 0, t0 + 6);
        step(6);
        sticky_clr_i[4] = 1'b1;
        step(1);
        sticky_clr_i[4] = 1'b0;
        chk("sticky_set_wins", N'(sticky_o[4]), N'(1));
        chk("sticky_bypass", sticky_o & BYP, '0);
        step(2);
`endif

        step(10);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_edge: got no pulse, required ch=%0d rise=%0b cyc=%0d", e.ch, e.rise, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
